mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Responder end of the core request/response bus used by the fetch and mem ports.
//  Accepts one request per transaction: enable pulse, mode, addr, wdata, wstrb.
//  Returns exactly one response_enable pulse with data after a fixed latency.
//  Backed by an internal word-addressed RAM. Serves as instruction/data memory or bench model.
// PARAMETERS
//  ADDR_WIDTH  12            word-index bits; RAM depth = 2**ADDR_WIDTH 32-bit words
//  LATENCY     2             cycles from request cycle to response cycle; legal 1..15
//  BASE_ADDR   32'h0000_0000 byte address of word 0; must be 4-byte aligned
// PORTS
//  clk                input   1   clock; all logic on rising edge
//  rst                input   1   synchronous reset, active-high
//  request_enable     input   1   1-cycle request strobe
//  req_mode           input   1   0 = read, 1 = write
//  req_addr           input   32  byte address; bits [1:0] ignored
//  req_wdata          input   32  write data
//  req_wstrb          input   4   byte enables for write; bit i -> wdata[8i+7:8i]
//  response_enable    output  1   1-cycle response strobe
//  resp_data          output  32  read data; 32'h0 for writes and faults
//  busy               output  1   transaction outstanding (request accepted, response not yet sent)
//  fault              output  1   sticky error flag; cleared only by rst
// BEHAVIOUR
//  Reset: response_enable=0, resp_data=0, busy=0, fault=0, state=IDLE, counter=0.
//  - RAM contents are not reset.
//  States: IDLE, WAIT.
//  - IDLE + request_enable: latch mode/addr/wdata/wstrb; counter=LATENCY-1; go WAIT; busy=1 next cycle.
//  - WAIT, counter!=0: decrement.
//  - WAIT, counter==0: perform access; assert response_enable for that one cycle with resp_data.
//    If request_enable is high in that same cycle, accept it as a new request and stay WAIT;
//    otherwise go IDLE.
//  Latency: request at cycle T -> response_enable high at T+LATENCY exactly. Back-to-back
//  throughput is one transaction per LATENCY cycles.
//  - LATENCY=1: WAIT is entered with counter=0; response at T+1.
//  Timing of busy:
//  - busy is high from T+1 through the response cycle inclusive.
//  - busy drops the cycle after the response unless a new request was accepted.
//  Address decode: offset = req_addr - BASE_ADDR (32-bit unsigned wrap); index = offset[31:2].
//  - In range iff offset[31:2] < 2**ADDR_WIDTH.
//  - Out of range: read returns 32'h0, write is dropped, fault set, response still issued.
//  Read: resp_data = RAM[index] as of the response cycle, i.e. it includes earlier writes.
//  Write: for each i with wstrb[i]=1, RAM[index][8i+7:8i] <= wdata byte i; other bytes are unchanged.
//  - Write is performed in the response cycle; resp_data = 32'h0.
//  - wstrb=4'b0000 write: no RAM change; response still issued; not a fault.
//  - wstrb is ignored for reads.
//  Protocol violation: request_enable while busy and not in the response cycle.
//  - The request is ignored and fault is set; the in-flight transaction completes unaffected.
//  resp_data holds its last value while response_enable=0. Initiators sample it only on the strobe.
//  rst mid-transaction: the pending response is discarded; no response_enable follows.
//  - A pending write is not performed.
// TESTING
//  1. LATENCY=2: write addr 0x10, data 0xDEADBEEF, wstrb 4'hF at T; read 0x10 at T+2
//     -> resp_en at T+2 with data 0; resp_en at T+4 with data 0xDEADBEEF.
//  2. Partial write: word 0x20 = 0x11223344; write wdata 0xAABBCCDD, wstrb 4'b0101
//     -> read 0x20 returns 0x11BB33DD.
//  3. Overlap, LATENCY=3: request at T, second request at T+1 -> second ignored; fault=1;
//     exactly one resp_en, at T+3. Request at T+3 is accepted -> resp_en at T+6.
//  4. Out of range, ADDR_WIDTH=4, BASE 0: read 0x40 -> resp_data 0, fault=1.
//     Write 0x40 does not alias word 0: read 0x0 is unchanged.
//  5. LATENCY=1 streaming: requests every cycle for 8 cycles -> 8 responses on consecutive cycles.
//     Each response carries the data for its own address, in order.
//  6. Reset: rst asserted at T+1 after a write request at T -> no resp_en.
//     busy=0 and fault=0 next cycle; later read shows the old word.

Source files
------------

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Responder end of the core request/response bus. It accepts one request
//   (read or byte-masked write) per transaction and returns exactly one
//   response_enable pulse, carrying resp_data, a fixed LATENCY cycles after the
//   request cycle. Storage is a word-addressed RAM of 2**ADDR_WIDTH x 32 bits
//   whose word 0 sits at byte address BASE_ADDR.
//
// Handshake: request_enable is a one-cycle strobe. A request is taken when the
//   block is IDLE, or in the cycle its current response is being issued.
//   response_enable is a one-cycle strobe; resp_data is meaningful only while it
//   is high and otherwise holds the last response. A request seen while a
//   transaction is in flight (and not in its response cycle) is dropped and
//   raises the sticky fault flag.
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   request_enable  request strobe
//   req_mode        0 = read, 1 = write
//   req_addr        byte address (bits [1:0] ignored)
//   req_wdata       write data
//   req_wstrb       byte enables for writes
//   response_enable response strobe
//   resp_data       read data (0 for writes and faulting accesses)
//   busy            transaction outstanding
//   fault           sticky error flag (protocol violation or out-of-range)
//   state_dbg       FSM state for observation: 0 = IDLE, 1 = WAIT
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request_enable,
    input  logic        req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        response_enable,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic        fault,
    output logic        state_dbg
);

    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [3:0]  COUNT_INIT = 4'(LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [3:0]              count, count_nxt;
    logic                    accept;
    logic                    violation;

    // Request captured at acceptance
    logic                    lat_mode;
    logic                    lat_in_range;
    logic [ADDR_WIDTH-1:0]   lat_index;
    logic [31:0]             lat_wdata;
    logic [3:0]              lat_wstrb;

    logic [31:0]             held_data;
    logic [31:0]             rd_value;
    logic                    do_write;
    logic [31:0]             mem [DEPTH];

    // Address decode. BASE_ADDR is word aligned, so subtracting the word parts
    // equals taking offset[31:2] of the full 32-bit wrapping difference.
    logic [29:0]             word_off;
    logic                    req_in_range;
    logic                    unused_addr_bits;

    assign word_off         = req_addr[31:2] - BASE_ADDR[31:2];
    assign req_in_range     = (word_off >> ADDR_WIDTH) == 30'd0;
    assign unused_addr_bits = ^req_addr[1:0];

    // Next-state / strobe logic
    always_comb begin
        state_nxt       = state;
        count_nxt       = count;
        accept          = 1'b0;
        violation       = 1'b0;
        response_enable = 1'b0;
        case (state)
            IDLE: begin
                if (request_enable) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                    count_nxt = COUNT_INIT;
                end
            end
            WAIT: begin
                if (count != 4'd0) begin
                    count_nxt = count - 4'd1;
                    violation = request_enable;
                end else begin
                    // Response cycle: a new request here is legal and chains
                    // directly into the next transaction.
                    response_enable = 1'b1;
                    if (request_enable) begin
                        accept    = 1'b1;
                        count_nxt = COUNT_INIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_value  = (lat_mode || !lat_in_range) ? 32'h0 : mem[lat_index];
    assign resp_data = response_enable ? rd_value : held_data;
    assign busy      = (state == WAIT);
    assign state_dbg = (state == WAIT);
    // A write is committed on the edge that closes its response cycle; a reset
    // arriving in that same cycle cancels it.
    assign do_write  = response_enable && lat_mode && lat_in_range && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= 4'd0;
            held_data    <= 32'h0;
            fault        <= 1'b0;
            lat_mode     <= 1'b0;
            lat_in_range <= 1'b0;
            lat_index    <= '0;
            lat_wdata    <= 32'h0;
            lat_wstrb    <= 4'h0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (accept) begin
                lat_mode     <= req_mode;
                lat_in_range <= req_in_range;
                lat_index    <= word_off[ADDR_WIDTH-1:0];
                lat_wdata    <= req_wdata;
                lat_wstrb    <= req_wstrb;
            end
            if (response_enable) begin
                held_data <= rd_value;
            end
            if (violation || (response_enable && !lat_in_range)) begin
                fault <= 1'b1;
            end
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_wstrb[i]) begin
                    mem[lat_index][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
